// File: rtl/traffic_pkg.sv
// Shared types and sizes for the light-sensor ADC scan scheduler.
package traffic_pkg;
  localparam int ADC_W = 10;
  localparam int N_CH  = 4;
  localparam int CH_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BUSY,
    SETTLE,
    LATCH,
    RECOVER
  } scan_state_t;
endpackage

// File: rtl/next_enabled_ch.sv
// Priority rotate of the channel mask starting at current+1, wrapping around;
// a single enabled channel resolves to itself.
module next_enabled_ch
  import traffic_pkg::*;
(
  input  logic [N_CH-1:0] i_mask,
  input  logic [CH_W-1:0] i_current,
  output logic [CH_W-1:0] o_next,
  output logic            o_none
);

  // w_hit[k] is the enable bit of channel current+k+1
  logic [N_CH-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      logic [CH_W-1:0] w_idx;
      assign w_idx     = i_current + CH_W'(gi + 1);
      assign w_hit[gi] = i_mask[w_idx];
    end
  endgenerate

  always_comb begin
    o_next = i_current;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_hit[k]) o_next = i_current + CH_W'(k + 1);
    end
  end

  assign o_none = ~|i_mask;

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin scan controller for the 4-channel serial ADC front end:
// frames on cs, latches results, derives dark flags, recovers a stalled master.
module adc_scan_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 2_000_000,
  parameter logic [ADC_W-1:0]  DARK_ON  = 10'd300,
  parameter logic [ADC_W-1:0]  DARK_OFF = 10'd400
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_scan_en,
  input  logic [N_CH-1:0]         i_ch_mask,
  input  logic                    i_adc_cs,
  input  logic [ADC_W-1:0]        i_adc_data,
  output logic                    o_adc_start,
  output logic [CH_W-1:0]         o_adc_channel,
  output logic [N_CH*ADC_W-1:0]   o_ch_result,
  output logic [N_CH-1:0]         o_ch_valid,
  output logic [N_CH-1:0]         o_dark,
  output logic                    o_sample_pulse,
  output logic [CH_W-1:0]         o_sample_ch,
  output logic                    o_timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT) > 2) ? $clog2(TIMEOUT) : 2;

  scan_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_cs_meta, r_cs_sync, r_cs_dly;
  logic [CH_W-1:0]  r_inflight_ch;
  logic             r_adc_start;
  logic [CH_W-1:0]  r_adc_channel;
  logic [ADC_W-1:0] r_ch_result [N_CH];
  logic [N_CH-1:0]  r_ch_valid, r_dark;
  logic             r_sample_pulse, r_timeout_err;
  logic [CH_W-1:0]  r_sample_ch;

  logic             w_cs_fall, w_cs_rise, w_wd_expired;
  logic             w_start_next, w_load_ch, w_latch, w_timeout;
  logic [CH_W-1:0]  w_adv_from, w_next_ch;
  logic             w_none;

  // cs idles high, so the synchroniser resets to 1 to avoid a false edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_dly  <= 1'b1;
    end else begin
      r_cs_meta <= i_adc_cs;
      r_cs_sync <= r_cs_meta;
      r_cs_dly  <= r_cs_sync;
    end
  end

  assign w_cs_fall    = r_cs_dly & ~r_cs_sync;
  assign w_cs_rise    = ~r_cs_dly & r_cs_sync;
  assign w_wd_expired = (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  assign w_adv_from = (r_state == IDLE)  ? CH_W'(N_CH - 1) :
                      (r_state == LATCH) ? r_inflight_ch : r_adc_channel;

  next_enabled_ch u_next_ch (
    .i_mask    (i_ch_mask),
    .i_current (w_adv_from),
    .o_next    (w_next_ch),
    .o_none    (w_none)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_scan_en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_none) w_state_next = ARM;
        ARM:     if (w_wd_expired) w_state_next = RECOVER;
                 else if (w_cs_fall) w_state_next = BUSY;
        BUSY:    if (w_wd_expired) w_state_next = RECOVER;
                 else if (w_cs_rise) w_state_next = SETTLE;
        SETTLE:  if (r_wd_cnt == CNT_W'(1)) w_state_next = LATCH;
        LATCH:   w_state_next = w_none ? IDLE : ARM;
        RECOVER: if (r_wd_cnt == CNT_W'(3)) w_state_next = w_none ? IDLE : ARM;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_start_next = (w_state_next == ARM) || (w_state_next == BUSY) ||
                   (w_state_next == SETTLE) || (w_state_next == LATCH);
    w_load_ch    = (w_state_next == ARM) &&
                   ((r_state == IDLE) || (r_state == LATCH) || (r_state == RECOVER));
    w_latch      = (r_state == LATCH) && i_scan_en;
    w_timeout    = ((r_state == ARM) || (r_state == BUSY)) && (w_state_next == RECOVER);
  end

  // One counter serves the watchdog, the SETTLE wait and the RECOVER hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                         r_wd_cnt <= '0;
    else if (w_state_next != r_state)  r_wd_cnt <= '0;
    else if (r_wd_cnt != '1)           r_wd_cnt <= r_wd_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_adc_start    <= 1'b0;
      r_adc_channel  <= '0;
      r_inflight_ch  <= '0;
      r_ch_valid     <= '0;
      r_dark         <= '0;
      r_sample_pulse <= 1'b0;
      r_sample_ch    <= '0;
      r_timeout_err  <= 1'b0;
      for (int n = 0; n < N_CH; n++) r_ch_result[n] <= '0;
    end else begin
      r_adc_start    <= w_start_next;
      r_sample_pulse <= w_latch;
      if (w_load_ch) r_adc_channel <= w_next_ch;
      if ((r_state == ARM) && (w_state_next == BUSY)) r_inflight_ch <= r_adc_channel;
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_latch) begin
        r_ch_result[r_inflight_ch] <= i_adc_data;
        r_ch_valid[r_inflight_ch]  <= 1'b1;
        r_sample_ch                <= r_inflight_ch;
        if (i_adc_data < DARK_ON)        r_dark[r_inflight_ch] <= 1'b1;
        else if (i_adc_data >= DARK_OFF) r_dark[r_inflight_ch] <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_result
      assign o_ch_result[gi*ADC_W +: ADC_W] = r_ch_result[gi];
    end
  endgenerate

  assign o_adc_start    = r_adc_start;
  assign o_adc_channel  = r_adc_channel;
  assign o_ch_valid     = r_ch_valid;
  assign o_dark         = r_dark;
  assign o_sample_pulse = r_sample_pulse;
  assign o_sample_ch    = r_sample_ch;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a cycle-level SPI master model.
module tb_adc_scan_scheduler;
  localparam int GAP = 12;
  localparam int LOW = 20;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  ch_mask;
  logic        adc_cs = 1'b1;
  logic [9:0]  adc_data = 10'd0;
  logic        adc_start;
  logic [1:0]  adc_channel;
  logic [39:0] ch_result;
  logic [3:0]  ch_valid;
  logic [3:0]  dark;
  logic        sample_pulse;
  logic [1:0]  sample_ch;
  logic        timeout_err;

  logic [9:0]  m_val [4];
  bit          m_en;
  int          m_cnt;
  bit          m_low;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_scan_scheduler #(
    .TIMEOUT  (TMO),
    .DARK_ON  (10'd300),
    .DARK_OFF (10'd400)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_scan_en      (scan_en),
    .i_ch_mask      (ch_mask),
    .i_adc_cs       (adc_cs),
    .i_adc_data     (adc_data),
    .o_adc_start    (adc_start),
    .o_adc_channel  (adc_channel),
    .o_ch_result    (ch_result),
    .o_ch_valid     (ch_valid),
    .o_dark         (dark),
    .o_sample_pulse (sample_pulse),
    .o_sample_ch    (sample_ch),
    .o_timeout_err  (timeout_err)
  );

  // SPI master model: cs high for GAP clk, low for LOW clk; held in reset while start=0
  always @(negedge clk) begin
    if (rst || !adc_start) begin
      adc_cs = 1'b1;
      m_cnt  = 0;
      m_low  = 1'b0;
    end else if (!m_low) begin
      if (m_en) begin
        if (m_cnt == GAP - 1) begin
          adc_cs   = 1'b0;
          m_low    = 1'b1;
          m_cnt    = 0;
          adc_data = m_val[adc_channel];
        end else begin
          m_cnt++;
        end
      end
    end else begin
      if (m_cnt == LOW - 1) begin
        adc_cs = 1'b1;
        m_low  = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic do_reset;
    rst      = 1'b1;
    scan_en  = 1'b0;
    ch_mask  = 4'h0;
    m_en     = 1'b1;
    m_val    = '{10'd100, 10'd200, 10'd300, 10'd400};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sample(output logic [1:0] ch, output bit got, output int cyc);
    got = 1'b0;
    ch  = 2'd0;
    cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sample_pulse) begin
        got = 1'b1;
        ch  = sample_ch;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (adc_start !== 1'b0 || adc_channel !== 2'd0 || ch_result !== 40'd0 ||
        ch_valid !== 4'd0 || dark !== 4'd0 || sample_pulse !== 1'b0 ||
        sample_ch !== 2'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: start=%b ch=%0d result=%h valid=%b dark=%b pulse=%b sch=%0d terr=%b required all zero",
               tag, adc_start, adc_channel, ch_result, ch_valid, dark, sample_pulse, sample_ch, timeout_err);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    scan_en = 1'b1;
    ch_mask = 4'hF;
    m_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_values");
    rst = 1'b0;
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_round_robin;
    logic [1:0] ch;
    bit got;
    int cyc;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    ch_mask = 4'hF;
    scan_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_sample(ch, got, cyc);
      checks++;
      if (!got || ch !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL rr_sample_ch[%0d]: got %0d (seen=%0d) required %0d", i, ch, got, exp_seq[i]);
      end
      checks++;
      if (ch_result[exp_seq[i]*10 +: 10] !== 10'(100 * (exp_seq[i] + 1))) begin
        errors++;
        $display("FAIL rr_result[%0d]: got %0d required %0d", i, ch_result[exp_seq[i]*10 +: 10], 100 * (exp_seq[i] + 1));
      end
      $display("round_robin: sample %0d ch=%0d result=%0d", i, ch, ch_result[exp_seq[i]*10 +: 10]);
    end
    checks++;
    if (ch_result !== {10'd400, 10'd300, 10'd200, 10'd100}) begin
      errors++;
      $display("FAIL rr_all_results: got %h required %h", ch_result, {10'd400, 10'd300, 10'd200, 10'd100});
    end
    checks++;
    if (ch_valid !== 4'hF) begin
      errors++;
      $display("FAIL rr_valid: got %b required 1111", ch_valid);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_mask_0101;
    logic [1:0] ch;
    bit got;
    int cyc;
    int exp_seq [3] = '{0, 2, 0};
    int exp_nxt [3] = '{2, 0, 2};
    do_reset();
    ch_mask = 4'b0101;
    scan_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_sample(ch, got, cyc);
      checks++;
      if (!got || ch !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL m5_sample_ch[%0d]: got %0d (seen=%0d) required %0d", i, ch, got, exp_seq[i]);
      end
      checks++;
      if (adc_channel !== 2'(exp_nxt[i])) begin
        errors++;
        $display("FAIL m5_adc_channel[%0d]: got %0d required %0d", i, adc_channel, exp_nxt[i]);
      end
      $display("mask_0101: sample %0d ch=%0d next adc_channel=%0d", i, ch, adc_channel);
    end
    checks++;
    if (ch_valid !== 4'b0101) begin
      errors++;
      $display("FAIL m5_valid: got %b required 0101", ch_valid);
    end
    checks++;
    if (ch_result[19:10] !== 10'd0 || ch_result[39:30] !== 10'd0) begin
      errors++;
      $display("FAIL m5_unused_results: got ch1=%0d ch3=%0d required 0 0", ch_result[19:10], ch_result[39:30]);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_hysteresis;
    logic [1:0] ch;
    bit got;
    int cyc;
    int hv [6] = '{350, 250, 350, 399, 400, 350};
    bit hd [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    ch_mask  = 4'b0001;
    m_val[0] = 10'(hv[0]);
    scan_en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_sample(ch, got, cyc);
      checks++;
      if (!got || ch_result[9:0] !== 10'(hv[i])) begin
        errors++;
        $display("FAIL hyst_result[%0d]: got %0d (seen=%0d) required %0d", i, ch_result[9:0], got, hv[i]);
      end
      checks++;
      if (dark[0] !== hd[i]) begin
        errors++;
        $display("FAIL hyst_dark[%0d]: got %b required %b", i, dark[0], hd[i]);
      end
      $display("hysteresis: value=%0d dark0=%b", ch_result[9:0], dark[0]);
      if (i < 5) m_val[0] = 10'(hv[i + 1]);
    end
    scan_en = 1'b0;
  endtask

  task automatic test_timeout;
    logic [1:0] ch;
    bit got;
    int cyc;
    int n;
    do_reset();
    ch_mask = 4'b0011;
    m_en    = 1'b0;
    scan_en = 1'b1;
    cyc = 0;
    while (!timeout_err && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc != TMO + 1) begin
      errors++;
      $display("FAIL to_detect: timeout_err=%b after %0d clk required 1 after %0d clk", timeout_err, cyc, TMO + 1);
    end
    n = 0;
    while (adc_start == 1'b0 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL to_start_low: got %0d clk required 4", n);
    end
    checks++;
    if (adc_channel !== 2'd1) begin
      errors++;
      $display("FAIL to_channel_adv: got %0d required 1", adc_channel);
    end
    $display("timeout: err after %0d clk, start low %0d clk, channel=%0d", cyc, n, adc_channel);
    m_en = 1'b1;
    wait_sample(ch, got, cyc);
    checks++;
    if (!got || ch !== 2'd1 || ch_result[19:10] !== 10'd200) begin
      errors++;
      $display("FAIL to_next_frame: got ch=%0d result=%0d (seen=%0d) required ch=1 result=200", ch, ch_result[19:10], got);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got %b required 1", timeout_err);
    end
    $display("timeout: recovery frame ch=%0d result=%0d", ch, ch_result[19:10]);
    scan_en = 1'b0;
  endtask

  task automatic wait_cs_low(input string tag);
    int n;
    n = 0;
    while (adc_cs !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (adc_cs !== 1'b0) begin
      errors++;
      $display("FAIL %s: cs got %b required 0 within 100 clk", tag, adc_cs);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_scan_en_drop;
    logic [1:0] ch;
    bit got;
    int cyc;
    int pulses;
    do_reset();
    ch_mask = 4'hF;
    scan_en = 1'b1;
    wait_sample(ch, got, cyc);
    checks++;
    if (!got || ch !== 2'd0) begin
      errors++;
      $display("FAIL drop_first: got ch=%0d (seen=%0d) required 0", ch, got);
    end
    wait_cs_low("drop_cs_wait");
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (adc_start !== 1'b0) begin
      errors++;
      $display("FAIL drop_start: got %b required 0", adc_start);
    end
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (sample_pulse) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL drop_no_pulse: got %0d pulses required 0", pulses);
    end
    checks++;
    if (ch_result !== {30'd0, 10'd100} || ch_valid !== 4'b0001) begin
      errors++;
      $display("FAIL drop_held: got result=%h valid=%b required %h 0001", ch_result, ch_valid, {30'd0, 10'd100});
    end
    scan_en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (adc_start !== 1'b1 || adc_channel !== 2'd0) begin
      errors++;
      $display("FAIL drop_restart: got start=%b ch=%0d required 1 0", adc_start, adc_channel);
    end
    wait_sample(ch, got, cyc);
    checks++;
    if (!got || ch !== 2'd0) begin
      errors++;
      $display("FAIL drop_resume: got ch=%0d (seen=%0d) required 0", ch, got);
    end
    $display("scan_en_drop: pulses while off=%0d, resumed on ch=%0d", pulses, ch);
    scan_en = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    logic [1:0] ch;
    bit got;
    int cyc;
    do_reset();
    ch_mask = 4'hF;
    scan_en = 1'b1;
    wait_sample(ch, got, cyc);
    wait_sample(ch, got, cyc);
    checks++;
    if (!got || ch !== 2'd1 || dark !== 4'b0011) begin
      errors++;
      $display("FAIL rstmid_pre: got ch=%0d dark=%b (seen=%0d) required ch=1 dark=0011", ch, dark, got);
    end
    wait_cs_low("rstmid_cs_wait");
    rst = 1'b1;
    #1;
    check_all_zero("rstmid_async");
    @(posedge clk);
    #1 rst = 1'b0;
    wait_sample(ch, got, cyc);
    checks++;
    if (!got || ch !== 2'd0 || ch_result[9:0] !== 10'd100 || cyc < GAP + LOW) begin
      errors++;
      $display("FAIL rstmid_first: got ch=%0d result=%0d after %0d clk (seen=%0d) required ch=0 result=100 after >=%0d clk",
               ch, ch_result[9:0], cyc, got, GAP + LOW);
    end
    $display("reset_mid_busy: first post-reset ch=%0d result=%0d after %0d clk", ch, ch_result[9:0], cyc);
    scan_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask_0101();
    test_hysteresis();
    test_timeout();
    test_scan_en_drop();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
